traffic_light_ctrl: RTL and testbench

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/traffic_pkg.sv | 53 +++++
 rtl/bcd_down_timer.sv | 32 +++
 rtl/traffic_light_ctrl.sv | 106 ++++++++++
 tb/tb_traffic_light_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types, lamp encodings and default phase durations for the traffic light controller.
package traffic_pkg;

    localparam int unsigned BCD_W = 8;

    localparam int unsigned DEF_T_MG      = 20;
    localparam int unsigned DEF_T_MY      = 3;
    localparam int unsigned DEF_T_AR      = 1;
    localparam int unsigned DEF_T_SG      = 10;
    localparam int unsigned DEF_T_SY      = 3;
    localparam int unsigned DEF_T_PED_CUT = 5;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        S_MG,
        S_MY,
        S_AR1,
        S_SG,
        S_SY,
        S_AR2
    } state_t;

    typedef struct packed {
        logic [2:0] main_light;
        logic [2:0] side_light;
        logic       walk;
    } lamps_t;

    // Two-digit packed BCD of a value in 0..99.
    function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
        return BCD_W'(((v / 32'd10) << 4) | (v % 32'd10));
    endfunction

    function automatic lamps_t lamps_of(input state_t s);
        lamps_t l;
        l = '{main_light: LIGHT_RED, side_light: LIGHT_RED, walk: 1'b0};
        case (s)
            S_MG:    l.main_light = LIGHT_GREEN;
            S_MY:    l.main_light = LIGHT_YELLOW;
            S_SG:    begin
                l.side_light = LIGHT_GREEN;
                l.walk       = 1'b1;
            end
            S_SY:    l.side_light = LIGHT_YELLOW;
            default: l = '{main_light: LIGHT_RED, side_light: LIGHT_RED, walk: 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/bcd_down_timer.sv
// Two-digit BCD down counter with synchronous load (priority over decrement).
module bcd_down_timer
    import traffic_pkg::*;
#(
    parameter logic [BCD_W-1:0] RESET_VALUE = 8'h00
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [BCD_W-1:0] load_value,
    input  logic             dec,
    output logic [BCD_W-1:0] value,
    output logic             is_one
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value <= RESET_VALUE;
        end else if (load) begin
            value <= load_value;
        end else if (dec) begin
            if (value[3:0] == 4'd0) begin
                value <= {value[7:4] - 4'd1, 4'd9};
            end else begin
                value <= {value[7:4], value[3:0] - 4'd1};
            end
        end
    end

    assign is_one = (value == 8'h01);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Main/side road traffic light sequencer with pedestrian-shortened main green.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned T_MG      = DEF_T_MG,
    parameter int unsigned T_MY      = DEF_T_MY,
    parameter int unsigned T_AR      = DEF_T_AR,
    parameter int unsigned T_SG      = DEF_T_SG,
    parameter int unsigned T_SY      = DEF_T_SY,
    parameter int unsigned T_PED_CUT = DEF_T_PED_CUT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tick_1s,
    input  logic             ped_req,
    output logic [2:0]       main_light,
    output logic [2:0]       side_light,
    output logic             walk,
    output logic [BCD_W-1:0] rem_bcd,
    output logic             ped_pend
);

    localparam logic [BCD_W-1:0] PED_CUT_BCD = to_bcd(T_PED_CUT);

    state_t           state;
    state_t           state_n;
    logic             tmr_load;
    logic             tmr_dec;
    logic [BCD_W-1:0] tmr_load_value;
    logic [BCD_W-1:0] tmr_value;
    logic             tmr_is_one;
    logic             ped_pend_n;
    lamps_t           lamps_n;

    function automatic logic [BCD_W-1:0] dur_bcd(input state_t s);
        case (s)
            S_MG:    return to_bcd(T_MG);
            S_MY:    return to_bcd(T_MY);
            S_SG:    return to_bcd(T_SG);
            S_SY:    return to_bcd(T_SY);
            default: return to_bcd(T_AR);
        endcase
    endfunction

    function automatic state_t next_state(input state_t s);
        case (s)
            S_MG:    return S_MY;
            S_MY:    return S_AR1;
            S_AR1:   return S_SG;
            S_SG:    return S_SY;
            S_SY:    return S_AR2;
            default: return S_MG;
        endcase
    endfunction

    bcd_down_timer #(
        .RESET_VALUE(to_bcd(T_MG))
    ) u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .dec        (tmr_dec),
        .value      (tmr_value),
        .is_one     (tmr_is_one)
    );

    // Phase advance has priority; the pedestrian cut beats a plain decrement.
    always_comb begin
        state_n        = state;
        tmr_load       = 1'b0;
        tmr_dec        = 1'b0;
        tmr_load_value = dur_bcd(state);
        if (tick_1s && tmr_is_one) begin
            state_n        = next_state(state);
            tmr_load       = 1'b1;
            tmr_load_value = dur_bcd(state_n);
        end else if ((state == S_MG) && ped_pend && (tmr_value > PED_CUT_BCD)) begin
            tmr_load       = 1'b1;
            tmr_load_value = PED_CUT_BCD;
        end else if (tick_1s) begin
            tmr_dec = 1'b1;
        end
        ped_pend_n = (ped_pend | ped_req) & ~((state_n == S_SG) && (state != S_SG));
        lamps_n    = lamps_of(state_n);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_MG;
            main_light <= LIGHT_GREEN;
            side_light <= LIGHT_RED;
            walk       <= 1'b0;
            ped_pend   <= 1'b0;
        end else begin
            state      <= state_n;
            main_light <= lamps_n.main_light;
            side_light <= lamps_n.side_light;
            walk       <= lamps_n.walk;
            ped_pend   <= ped_pend_n;
        end
    end

    assign rem_bcd = tmr_value;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed scoreboard bench: stimulus queues expected lamp/timer snapshots, a monitor compares them.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       tick_1s = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic [7:0] rem_bcd;
    logic       ped_pend;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    typedef struct packed {
        logic [2:0] m;
        logic [2:0] s;
        logic       w;
        logic       p;
        logic [7:0] r;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    obs_t  mon_exp;
    obs_t  mon_act;
    string mon_name;

    traffic_light_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .tick_1s    (tick_1s),
        .ped_req    (ped_req),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .rem_bcd    (rem_bcd),
        .ped_pend   (ped_pend)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    // Monitor: one snapshot per cycle, taken mid-period.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {main_light, side_light, walk, ped_pend, rem_bcd};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s: got main=%b side=%b walk=%b pend=%b rem=%h, expected main=%b side=%b walk=%b pend=%b rem=%h",
                         mon_name, mon_act.m, mon_act.s, mon_act.w, mon_act.p, mon_act.r,
                         mon_exp.m, mon_exp.s, mon_exp.w, mon_exp.p, mon_exp.r);
            end
        end
    end

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic chk(input string nm, input logic [2:0] m, input logic [2:0] s,
                       input logic w, input logic p, input logic [7:0] r);
        exp_q.push_back({m, s, w, p, r});
        name_q.push_back(nm);
    endtask

    task automatic cyc(input logic t, input logic p);
        tick_1s = t;
        ped_req = p;
        @(posedge clk);
        #1;
        tick_1s = 1'b0;
        ped_req = 1'b0;
    endtask

    task automatic tick_chk(input string nm, input logic [2:0] m, input logic [2:0] s,
                            input logic w, input logic p, input logic [7:0] r);
        cyc(1'b1, 1'b0);
        chk(nm, m, s, w, p, r);
        cyc(1'b0, 1'b0);
    endtask

    // From a state entry (timer == dur), tick down to 1 checking every second.
    task automatic run_state(input string nm, input logic [2:0] m, input logic [2:0] s,
                             input logic w, input logic p, input int dur);
        for (int k = 1; k < dur; k++) begin
            tick_chk(nm, m, s, w, p, bcd(dur - k));
        end
    endtask

    task automatic rest_from_my(input logic p);
        run_state("my_count", Y, R, 1'b0, p, 3);
        tick_chk("ar1_entry", R, R, 1'b0, p, 8'h01);
        tick_chk("sg_entry", R, G, 1'b1, 1'b0, 8'h10);
        run_state("sg_count", R, G, 1'b1, 1'b0, 10);
        tick_chk("sy_entry", R, Y, 1'b0, 1'b0, 8'h03);
        run_state("sy_count", R, Y, 1'b0, 1'b0, 3);
        tick_chk("ar2_entry", R, R, 1'b0, 1'b0, 8'h01);
        tick_chk("mg_reentry", G, R, 1'b0, 1'b0, 8'h20);
    endtask

    initial begin
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", G, R, 1'b0, 1'b0, 8'h20);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc(1'b0, 1'b0);
        chk("post_release", G, R, 1'b0, 1'b0, 8'h20);
        cyc(1'b0, 1'b0);

        // Plain full cycle.
        run_state("mg_count", G, R, 1'b0, 1'b0, 20);
        tick_chk("my_entry", Y, R, 1'b0, 1'b0, 8'h03);
        rest_from_my(1'b0);

        // Pedestrian at 15 s remaining shortens green to 5 s.
        for (int k = 1; k <= 5; k++) tick_chk("mg_pre_ped", G, R, 1'b0, 1'b0, bcd(20 - k));
        cyc(1'b0, 1'b1);
        chk("ped_latch_15", G, R, 1'b0, 1'b1, 8'h15);
        cyc(1'b0, 1'b0);
        chk("ped_cut_05", G, R, 1'b0, 1'b1, 8'h05);
        cyc(1'b0, 1'b0);
        run_state("mg_after_cut", G, R, 1'b0, 1'b1, 5);
        tick_chk("my_entry_ped", Y, R, 1'b0, 1'b1, 8'h03);
        rest_from_my(1'b1);

        // Pedestrian at 3 s remaining leaves timing alone; request at SG entry is cleared.
        for (int k = 1; k <= 17; k++) tick_chk("mg_pre_ped3", G, R, 1'b0, 1'b0, bcd(20 - k));
        cyc(1'b0, 1'b1);
        chk("ped_latch_03", G, R, 1'b0, 1'b1, 8'h03);
        cyc(1'b0, 1'b0);
        chk("ped_no_cut_03", G, R, 1'b0, 1'b1, 8'h03);
        cyc(1'b0, 1'b0);
        run_state("mg_tail_ped3", G, R, 1'b0, 1'b1, 3);
        tick_chk("my_entry_ped3", Y, R, 1'b0, 1'b1, 8'h03);
        run_state("my_count_ped3", Y, R, 1'b0, 1'b1, 3);
        tick_chk("ar1_entry_ped3", R, R, 1'b0, 1'b1, 8'h01);
        cyc(1'b1, 1'b1);
        chk("sg_entry_clear_wins", R, G, 1'b1, 1'b0, 8'h10);
        cyc(1'b0, 1'b0);
        chk("sg_pend_stays_clear", R, G, 1'b1, 1'b0, 8'h10);
        cyc(1'b0, 1'b0);
        run_state("sg_count_b", R, G, 1'b1, 1'b0, 10);
        tick_chk("sy_entry_b", R, Y, 1'b0, 1'b0, 8'h03);

        // No ticks for 1000 clocks: everything holds.
        for (int j = 0; j < 4; j++) begin
            repeat (250) cyc(1'b0, 1'b0);
            chk("sy_hold", R, Y, 1'b0, 1'b0, 8'h03);
        end
        cyc(1'b0, 1'b0);
        run_state("sy_count_b", R, Y, 1'b0, 1'b0, 3);
        tick_chk("ar2_entry_b", R, R, 1'b0, 1'b0, 8'h01);
        tick_chk("mg_entry_b", G, R, 1'b0, 1'b0, 8'h20);

        // Pedestrian and tick together at 12 s remaining.
        for (int k = 1; k <= 8; k++) tick_chk("mg_pre_ped12", G, R, 1'b0, 1'b0, bcd(20 - k));
        cyc(1'b1, 1'b1);
        chk("ped_tick_11", G, R, 1'b0, 1'b1, 8'h11);
        cyc(1'b0, 1'b0);
        chk("ped_tick_cut_05", G, R, 1'b0, 1'b1, 8'h05);
        cyc(1'b0, 1'b0);
        run_state("mg_after_cut_b", G, R, 1'b0, 1'b1, 5);
        tick_chk("my_entry_c", Y, R, 1'b0, 1'b1, 8'h03);
        run_state("my_count_c", Y, R, 1'b0, 1'b1, 3);
        tick_chk("ar1_entry_c", R, R, 1'b0, 1'b1, 8'h01);
        tick_chk("sg_entry_c", R, G, 1'b1, 1'b0, 8'h10);
        for (int k = 1; k <= 3; k++) tick_chk("sg_pre_reset", R, G, 1'b1, 1'b0, bcd(10 - k));

        // Asynchronous reset between clock edges, then restart from S_MG.
        @(posedge clk);
        #2;
        rstn = 1'b0;
        chk("async_reset", G, R, 1'b0, 1'b0, 8'h20);
        @(posedge clk);
        #1;
        chk("reset_held", G, R, 1'b0, 1'b0, 8'h20);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc(1'b0, 1'b0);
        chk("post_reset_mg", G, R, 1'b0, 1'b0, 8'h20);
        cyc(1'b0, 1'b0);
        tick_chk("first_tick_after_reset", G, R, 1'b0, 1'b0, 8'h19);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
